// File: rtl/forwarding_unit.sv
// Forwarding detector for one producing stage: flags which source operands match
// the in-flight destination register, registers the selects and counts forwarding events.
module forwarding_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [4:0]           ADDR1,
    input  logic [4:0]           ADDR2,
    input  logic [4:0]           STAGE_RD,
    output logic [1:0]           FORWARD_EN,
    output logic [1:0]           FORWARD_EN_Q,
    output logic [CNT_WIDTH-1:0] FWD1_COUNT,
    output logic [CNT_WIDTH-1:0] FWD2_COUNT,
    output logic [CNT_WIDTH-1:0] BOTH_COUNT
);

    logic                 w_rd_nonzero;
    logic [1:0]           w_fwd;
    logic                 w_both;
    logic [1:0]           r_fwd_q;
    logic [CNT_WIDTH-1:0] r_fwd1_cnt;
    logic [CNT_WIDTH-1:0] r_fwd2_cnt;
    logic [CNT_WIDTH-1:0] r_both_cnt;

    // x0 is hardwired zero, so a write to it is never a real producer.
    // Plain == / != let unknown addresses propagate X instead of hiding them.
    assign w_rd_nonzero = (STAGE_RD != 5'd0);
    assign w_fwd[0]     = (ADDR1 == STAGE_RD) & w_rd_nonzero;
    assign w_fwd[1]     = (ADDR2 == STAGE_RD) & w_rd_nonzero;
    assign w_both       = w_fwd[0] & w_fwd[1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fwd_q    <= 2'b00;
            r_fwd1_cnt <= '0;
            r_fwd2_cnt <= '0;
            r_both_cnt <= '0;
        end else begin
            r_fwd_q <= w_fwd;
            // Counters stick at all-ones rather than wrapping.
            if (w_fwd[0] && !(&r_fwd1_cnt)) r_fwd1_cnt <= r_fwd1_cnt + 1'b1;
            if (w_fwd[1] && !(&r_fwd2_cnt)) r_fwd2_cnt <= r_fwd2_cnt + 1'b1;
            if (w_both   && !(&r_both_cnt)) r_both_cnt <= r_both_cnt + 1'b1;
        end
    end

    assign FORWARD_EN   = w_fwd;
    assign FORWARD_EN_Q = r_fwd_q;
    assign FWD1_COUNT   = r_fwd1_cnt;
    assign FWD2_COUNT   = r_fwd2_cnt;
    assign BOTH_COUNT   = r_both_cnt;

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: a vector table for the combinational selects,
// then hand-written sequences for latency, counting, async reset and saturation.
module tb_forwarding_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [4:0]  stage_rd;

    logic [1:0]  fwd_en;
    logic [1:0]  fwd_en_q;
    logic [15:0] fwd1_cnt;
    logic [15:0] fwd2_cnt;
    logic [15:0] both_cnt;

    logic [1:0]  s_fwd_en;
    logic [1:0]  s_fwd_en_q;
    logic [1:0]  s_fwd1_cnt;
    logic [1:0]  s_fwd2_cnt;
    logic [1:0]  s_both_cnt;

    int pass_cnt;
    int total_cnt;

    forwarding_unit #(.CNT_WIDTH(16)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .ADDR1        (addr1),
        .ADDR2        (addr2),
        .STAGE_RD     (stage_rd),
        .FORWARD_EN   (fwd_en),
        .FORWARD_EN_Q (fwd_en_q),
        .FWD1_COUNT   (fwd1_cnt),
        .FWD2_COUNT   (fwd2_cnt),
        .BOTH_COUNT   (both_cnt)
    );

    forwarding_unit #(.CNT_WIDTH(2)) dut_s (
        .CLK          (clk),
        .RESET        (rst),
        .ADDR1        (addr1),
        .ADDR2        (addr2),
        .STAGE_RD     (stage_rd),
        .FORWARD_EN   (s_fwd_en),
        .FORWARD_EN_Q (s_fwd_en_q),
        .FWD1_COUNT   (s_fwd1_cnt),
        .FWD2_COUNT   (s_fwd2_cnt),
        .BOTH_COUNT   (s_both_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] rd;
        logic [1:0] exp_en;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
        addr1    = a1;
        addr2    = a2;
        stage_rd = rd;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        drive(5'd0, 5'd0, 5'd0);

        vecs[0]  = '{5'd1,  5'd2,  5'd0,  2'b00};
        vecs[1]  = '{5'd1,  5'd1,  5'd1,  2'b11};
        vecs[2]  = '{5'd1,  5'd2,  5'd1,  2'b01};
        vecs[3]  = '{5'd2,  5'd1,  5'd1,  2'b10};
        vecs[4]  = '{5'd0,  5'd0,  5'd0,  2'b00};
        vecs[5]  = '{5'd5,  5'd5,  5'd0,  2'b00};
        vecs[6]  = '{5'd31, 5'd3,  5'd31, 2'b01};
        vecs[7]  = '{5'd7,  5'd31, 5'd31, 2'b10};
        vecs[8]  = '{5'd31, 5'd31, 5'd31, 2'b11};
        vecs[9]  = '{5'd0,  5'd0,  5'd5,  2'b00};
        vecs[10] = '{5'd4,  5'd9,  5'd3,  2'b00};

        repeat (2) @(negedge clk);

        // Selects are combinational and live even while reset holds the registers.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].a1, vecs[i].a2, vecs[i].rd);
            #1;
            check($sformatf("fwd_en_vec%0d", i), 32'(fwd_en), 32'(vecs[i].exp_en));
            @(posedge clk);
            #1;
            check($sformatf("q_in_reset_vec%0d", i), 32'(fwd_en_q), 32'd0);
            check($sformatf("cnt_in_reset_vec%0d", i), 32'(fwd1_cnt | fwd2_cnt | both_cnt), 32'd0);
        end

        // Both operands forward: one edge updates Q and all three counters.
        @(negedge clk);
        rst = 1'b0;
        drive(5'd1, 5'd1, 5'd1);
        #1;
        check("both_en", 32'(fwd_en), 32'd3);
        @(posedge clk);
        #1;
        check("both_q", 32'(fwd_en_q), 32'd3);
        check("both_fwd1", 32'(fwd1_cnt), 32'd1);
        check("both_fwd2", 32'(fwd2_cnt), 32'd1);
        check("both_both", 32'(both_cnt), 32'd1);
        check("both_s_both", 32'(s_both_cnt), 32'd1);

        // x0 destination: five edges with no counting.
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0);
        repeat (5) @(posedge clk);
        #1;
        check("x0_q", 32'(fwd_en_q), 32'd0);
        check("x0_fwd1", 32'(fwd1_cnt), 32'd1);
        check("x0_fwd2", 32'(fwd2_cnt), 32'd1);
        check("x0_both", 32'(both_cnt), 32'd1);

        // Async reset away from any clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_clr_fwd1", 32'(fwd1_cnt), 32'd0);
        check("async_clr_both", 32'(both_cnt), 32'd0);
        #1;
        rst = 1'b0;
        drive(5'd1, 5'd2, 5'd1);
        repeat (3) @(posedge clk);
        #1;
        check("fwd1x3_fwd1", 32'(fwd1_cnt), 32'd3);
        check("fwd1x3_fwd2", 32'(fwd2_cnt), 32'd0);
        check("fwd1x3_both", 32'(both_cnt), 32'd0);
        check("fwd1x3_q", 32'(fwd_en_q), 32'd1);

        // Reset mid-count, between edges.
        #2;
        rst = 1'b1;
        #1;
        check("midrst_fwd1", 32'(fwd1_cnt), 32'd0);
        check("midrst_q", 32'(fwd_en_q), 32'd0);
        check("midrst_en", 32'(fwd_en), 32'd1);
        check("midrst_s_fwd1", 32'(s_fwd1_cnt), 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_fwd1", 32'(fwd1_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_fwd1", 32'(fwd1_cnt), 32'd1);
        check("resume_q", 32'(fwd_en_q), 32'd1);

        // Saturation on the 2-bit instance; the 16-bit one keeps counting.
        @(negedge clk);
        drive(5'd1, 5'd1, 5'd1);
        repeat (6) @(posedge clk);
        #1;
        check("sat_s_fwd1", 32'(s_fwd1_cnt), 32'd3);
        check("sat_s_fwd2", 32'(s_fwd2_cnt), 32'd3);
        check("sat_s_both", 32'(s_both_cnt), 32'd3);
        check("sat_fwd1", 32'(fwd1_cnt), 32'd7);
        check("sat_fwd2", 32'(fwd2_cnt), 32'd6);
        check("sat_both", 32'(both_cnt), 32'd6);
        check("sat_s_q", 32'(s_fwd_en_q), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
FORWARDING_UNIT -- requirements
Module: forwarding_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of each forwarding-event counter.
REQ-002 CLK  input  1  single clock; all sequential logic updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 ADDR1  input  5  source register 1 address of the consuming instruction.
REQ-005 ADDR2  input  5  source register 2 address of the consuming instruction.
REQ-006 STAGE_RD  input  5  destination register address held in the producing pipeline stage.
REQ-007 FORWARD_EN  output  2  combinational forward selects: bit0 forwards ADDR1, bit1 forwards ADDR2.
REQ-008 FORWARD_EN_Q  output  2  FORWARD_EN registered on CLK.
REQ-009 FWD1_COUNT  output  CNT_WIDTH  count of cycles with FORWARD_EN[0]=1.
REQ-010 FWD2_COUNT  output  CNT_WIDTH  count of cycles with FORWARD_EN[1]=1.
REQ-011 BOTH_COUNT  output  CNT_WIDTH  count of cycles with FORWARD_EN=2'b11.

Function
REQ-012 FORWARD_EN[0] SHALL be 1 iff ADDR1 == STAGE_RD and STAGE_RD != 0.
REQ-013 FORWARD_EN[1] SHALL be 1 iff ADDR2 == STAGE_RD and STAGE_RD != 0.
REQ-014 FORWARD_EN SHALL be purely combinational with zero-cycle latency, independent of CLK and RESET.
REQ-015 Register x0 never forwards: STAGE_RD == 0 forces FORWARD_EN = 2'b00 regardless of ADDR1/ADDR2.
REQ-016 ADDR1 == ADDR2 == STAGE_RD != 0 SHALL yield FORWARD_EN = 2'b11.
REQ-017 FORWARD_EN_Q SHALL take the value of FORWARD_EN at each rising CLK edge (1-cycle latency).
REQ-018 Each counter SHALL increment by 1 on a rising CLK edge when its condition (REQ-009..011) holds at that edge.
REQ-019 Counters SHALL saturate at all-ones and not wrap.
REQ-020 A 2'b11 cycle SHALL increment FWD1_COUNT, FWD2_COUNT and BOTH_COUNT in the same edge.
REQ-021 Any X/Z on an input address SHALL NOT be masked; outputs follow standard Verilog evaluation.

Reset
REQ-022 RESET high SHALL immediately, without waiting for CLK, set FORWARD_EN_Q = 2'b00 and all counters to 0.
REQ-023 While RESET is high, registers SHALL hold reset values; FORWARD_EN continues to track inputs.
REQ-024 Reset asserted mid-count SHALL clear counters at once; counting resumes on the first rising edge after RESET falls.

Verification
REQ-025 ADDR1=1, ADDR2=2, STAGE_RD=0 -> FORWARD_EN=2'b00.
REQ-026 ADDR1=1, ADDR2=1, STAGE_RD=1 -> FORWARD_EN=2'b11; after one edge, FORWARD_EN_Q=2'b11 and BOTH_COUNT increments by 1.
REQ-027 ADDR1=1, ADDR2=2, STAGE_RD=1 -> FORWARD_EN=2'b01; ADDR1=2, ADDR2=1, STAGE_RD=1 -> FORWARD_EN=2'b10.
REQ-028 ADDR1=ADDR2=STAGE_RD=0 -> FORWARD_EN=2'b00, and no counter increments over 5 edges.
REQ-029 Hold FORWARD_EN=2'b01 for 3 edges -> FWD1_COUNT=3; assert RESET between edges -> all counters read 0 immediately.
REQ-030 With CNT_WIDTH=2, hold FORWARD_EN=2'b11 for 6 edges -> all three counters read 3 (saturated).
